rtc_time_counter: RTL and testbench
===================================

RTC_TIME_COUNTER -- requirements
Module: rtc_time_counter

Interface
REQ-001 SHALL have parameter INIT_HOUR, default 0, hour (0..23) loaded on reset.
REQ-002 SHALL have port i_clk, input, 1, system clock (50 MHz), the only clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-004 SHALL have port i_tick, input, 1, 1 Hz square wave from the clock divider, i_clk-synchronous.
REQ-005 SHALL have port i_run, input, 1, 1 = time advances, 0 = time frozen.
REQ-006 SHALL have port i_set_valid, input, 1, single-cycle load strobe.
REQ-007 SHALL have ports i_set_hh, i_set_mm and i_set_ss, inputs, 5/6/6 bits, load value, always 24-hour.
REQ-008 SHALL have ports o_hour, o_min and o_sec, outputs, 5/6/6 bits, current time.
REQ-009 SHALL have port o_pm, output, 1, PM indicator.
REQ-010 SHALL have port o_sec_pulse, output, 1, one-cycle pulse on each second advance.
REQ-011 SHALL have port o_day_pulse, output, 1, one-cycle pulse on the 23:59:59->00:00:00 wrap.
REQ-012 SHALL have port o_set_err, output, 1, one-cycle pulse on a rejected load.

Function
REQ-013 SHALL register i_tick into tick_q every cycle; rise = i_tick & ~tick_q.
REQ-014 SHALL advance time one second on the edge where rise=1 and i_run=1, with outputs updated the following cycle.
REQ-015 SHALL discard a rise that occurs while i_run=0; it SHALL NOT be queued.
REQ-016 SHALL increment seconds 0..59; 59 SHALL wrap to 0 and carry into minutes.
REQ-017 SHALL increment minutes 0..59; 59 with a carry SHALL wrap to 0 and carry into hours.
REQ-018 SHALL count the internal hour 0..23; 23 with a carry SHALL wrap to 0.
REQ-019 SHALL assert o_sec_pulse in the same cycle as the seconds update.
REQ-020 SHALL assert o_day_pulse only on the 23:59:59->00:00:00 step, coincident with o_sec_pulse.
REQ-021 SHALL accept a load when i_set_valid=1 and hh<=23, mm<=59, ss<=59; time SHALL equal the load value the next cycle.
REQ-022 SHALL leave time unchanged on an out-of-range load and pulse o_set_err for one cycle.
REQ-023 SHALL give a load priority over a simultaneous rise; that tick SHALL be discarded with no o_sec_pulse.
REQ-024 SHALL NOT change time or assert pulses absent a rise or a load.
REQ-025 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-026 SHALL, when rst=0 at an i_clk edge, set o_sec=0, o_min=0, internal hour=INIT_HOUR, tick_q=0, and all pulses=0.
REQ-027 SHALL let reset override any load or tick in the same cycle, including a reset mid-rollover.
REQ-028 SHALL NOT generate a rise on the first cycle after reset if i_tick is already high; it SHALL wait for a true 0->1 transition.

Configuration
REQ-029 SHALL, with RTC_TWELVE_HOUR_EN defined, map the internal hour to o_hour (0->12, 1..12->1..12, 13..23->1..11) and set o_pm=1 for internal hours 12..23.
REQ-030 SHALL, without RTC_TWELVE_HOUR_EN, make o_hour equal the internal hour (0..23) and tie o_pm to 0.
REQ-031 SHALL keep i_set_hh 24-hour in both builds.

Verification
REQ-032 Reset, then 3 i_tick rising edges with i_run=1 -> o_sec=3, three o_sec_pulse, o_min=0.
REQ-033 Load 23:59:59, then 1 rising edge -> 00:00:00, o_day_pulse=1 for exactly one cycle.
REQ-034 Load hh=24, mm=0, ss=0 -> o_set_err pulse, time unchanged.
REQ-035 i_set_valid and a rise in the same cycle, load 10:20:30 -> 10:20:30, no o_sec_pulse.
REQ-036 i_run=0 across 2 rising edges, then i_run=1 with 1 edge -> o_sec advances by exactly 1.
REQ-037 With RTC_TWELVE_HOUR_EN: load 00:00:00 -> o_hour=12, o_pm=0; load 13:05:00 -> o_hour=1, o_pm=1.

Source files
------------

// File: rtl/rtc_time_counter.sv
// Real-time hh:mm:ss counter stepped by rising edges of a 1 Hz tick, with a validated load port.
// Define RTC_TWELVE_HOUR_EN to present o_hour in 12-hour form with o_pm; the default build is 24-hour.
module rtc_time_counter #(
    parameter int INIT_HOUR = 0
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_run,
    input  logic       i_set_valid,
    input  logic [4:0] i_set_hh,
    input  logic [5:0] i_set_mm,
    input  logic [5:0] i_set_ss,
    output logic [4:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic       o_pm,
    output logic       o_sec_pulse,
    output logic       o_day_pulse,
    output logic       o_set_err
);

    localparam logic [4:0] INIT_HOUR_L = 5'(INIT_HOUR);

    // Returns {pm, displayed_hour} for an internal 0..23 hour.
    function automatic logic [5:0] disp_hour(input logic [4:0] h);
`ifdef RTC_TWELVE_HOUR_EN
        logic [4:0] hh;
        logic       pm;
        pm = (h >= 5'd12);
        if (h == 5'd0) begin
            hh = 5'd12;
        end else if (h <= 5'd12) begin
            hh = h;
        end else begin
            hh = h - 5'd12;
        end
        return {pm, hh};
`else
        return {1'b0, h};
`endif
    endfunction

    localparam logic [5:0] INIT_DISP = disp_hour(INIT_HOUR_L);

    logic       tick_q, tick_d;
    logic       seen_low_q, seen_low_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic [4:0] hour_disp_q, hour_disp_d;
    logic       pm_q, pm_d;
    logic       sec_pulse_q, sec_pulse_d;
    logic       day_pulse_q, day_pulse_d;
    logic       set_err_q, set_err_d;
    logic       rise;
    logic       set_ok;

    always_comb begin
        tick_d      = i_tick;
        // A rise only counts once i_tick has been seen low, so a tick already high at reset is ignored.
        seen_low_d  = seen_low_q | ~i_tick;
        rise        = i_tick & ~tick_q & seen_low_q;
        set_ok      = (i_set_hh <= 5'd23) && (i_set_mm <= 6'd59) && (i_set_ss <= 6'd59);
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        set_err_d   = 1'b0;

        if (i_set_valid) begin
            if (set_ok) begin
                sec_d  = i_set_ss;
                min_d  = i_set_mm;
                hour_d = i_set_hh;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (rise && i_run) begin
            sec_pulse_d = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    if (hour_q == 5'd23) begin
                        hour_d      = 5'd0;
                        day_pulse_d = 1'b1;
                    end else begin
                        hour_d = hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        {pm_d, hour_disp_d} = disp_hour(hour_d);
    end

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            tick_q      <= 1'b0;
            seen_low_q  <= ~i_tick;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= INIT_HOUR_L;
            hour_disp_q <= INIT_DISP[4:0];
            pm_q        <= INIT_DISP[5];
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            seen_low_q  <= seen_low_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            hour_disp_q <= hour_disp_d;
            pm_q        <= pm_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
            set_err_q   <= set_err_d;
        end
    end

    assign o_hour      = hour_disp_q;
    assign o_min       = min_q;
    assign o_sec       = sec_q;
    assign o_pm        = pm_q;
    assign o_sec_pulse = sec_pulse_q;
    assign o_day_pulse = day_pulse_q;
    assign o_set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Self-checking bench for rtc_time_counter: a reference time model pushes expected outputs per cycle,
// and each scenario task drains and compares them against the sampled outputs.
module tb_rtc_time_counter;

    localparam int INIT_H = 5;

    logic       i_clk;
    logic       rst;
    logic       i_tick;
    logic       i_run;
    logic       i_set_valid;
    logic [4:0] i_set_hh;
    logic [5:0] i_set_mm;
    logic [5:0] i_set_ss;
    logic [4:0] o_hour;
    logic [5:0] o_min;
    logic [5:0] o_sec;
    logic       o_pm;
    logic       o_sec_pulse;
    logic       o_day_pulse;
    logic       o_set_err;

    rtc_time_counter #(.INIT_HOUR(INIT_H)) dut (
        .i_clk       (i_clk),
        .rst         (rst),
        .i_tick      (i_tick),
        .i_run       (i_run),
        .i_set_valid (i_set_valid),
        .i_set_hh    (i_set_hh),
        .i_set_mm    (i_set_mm),
        .i_set_ss    (i_set_ss),
        .o_hour      (o_hour),
        .o_min       (o_min),
        .o_sec       (o_sec),
        .o_pm        (o_pm),
        .o_sec_pulse (o_sec_pulse),
        .o_day_pulse (o_day_pulse),
        .o_set_err   (o_set_err)
    );

    // Clock / reset block
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Packed record: [20:16] hour, [15:10] min, [9:4] sec, [3] pm, [2] sec_pulse, [1] day_pulse, [0] set_err
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];
    logic [20:0] e, o;
    int          tests_run = 0;
    int          tests_failed = 0;

    // Reference model state
    int   m_h, m_m, m_s;
    logic m_prev;

    function automatic logic [4:0] model_hour(input int h);
`ifdef RTC_TWELVE_HOUR_EN
        return ((h % 12) == 0) ? 5'd12 : 5'(h % 12);
`else
        return 5'(h);
`endif
    endfunction

    function automatic logic model_pm(input int h);
`ifdef RTC_TWELVE_HOUR_EN
        return h >= 12;
`else
        return 1'b0;
`endif
    endfunction

    // Driver: apply one cycle of inputs, push the model's expectation, sample the DUT after the edge.
    task automatic drive(input logic r, input logic tick, input logic run, input logic sv,
                         input logic [4:0] hh, input logic [5:0] mm, input logic [5:0] ss);
        logic sp, dp, err;
        rst = r; i_tick = tick; i_run = run; i_set_valid = sv;
        i_set_hh = hh; i_set_mm = mm; i_set_ss = ss;
        sp = 1'b0; dp = 1'b0; err = 1'b0;
        if (!r) begin
            m_h = INIT_H; m_m = 0; m_s = 0;
        end else if (sv) begin
            if (hh <= 23 && mm <= 59 && ss <= 59) begin
                m_h = int'(hh); m_m = int'(mm); m_s = int'(ss);
            end else begin
                err = 1'b1;
            end
        end else if (tick && !m_prev && run) begin
            sp = 1'b1;
            m_s = m_s + 1;
            if (m_s == 60) begin m_s = 0; m_m = m_m + 1; end
            if (m_m == 60) begin m_m = 0; m_h = m_h + 1; end
            if (m_h == 24) begin m_h = 0; dp = 1'b1; end
        end
        m_prev = tick;
        exp_q.push_back({model_hour(m_h), 6'(m_m), 6'(m_s), model_pm(m_h), sp, dp, err});
        @(posedge i_clk);
        #1;
        obs_q.push_back({o_hour, o_min, o_sec, o_pm, o_sec_pulse, o_day_pulse, o_set_err});
    endtask

    task automatic idle(input logic tick, input logic run);
        drive(1'b1, tick, run, 1'b0, 5'd0, 6'd0, 6'd0);
    endtask

    task automatic load(input logic tick, input logic [4:0] hh, input logic [5:0] mm, input logic [5:0] ss);
        drive(1'b1, tick, 1'b1, 1'b1, hh, mm, ss);
    endtask

    task automatic test_reset;
        int cyc = 0;
        // Reset dominates a valid load and a tick; i_tick already high at release must not count.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 6'd20, 6'd30);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset cycle %0d: got %h, expected %h", cyc, o, e);
            end
            cyc++;
        end
        tests_run++;
        if (o[20:16] !== model_hour(INIT_H) || o[15:4] !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_time: got %h, expected hour %0d 00:00", o, INIT_H);
        end
    endtask

    task automatic test_count;
        int cyc = 0;
        int pulses = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b1);
            idle(1'b1, 1'b1);
            idle(1'b0, 1'b1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o[2]) pulses++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL count cycle %0d: got %h, expected %h", cyc, o, e);
            end
            cyc++;
        end
        tests_run++;
        if (pulses !== 3 || o[9:4] !== 6'd3 || o[15:10] !== 6'd0) begin
            tests_failed++;
            $display("FAIL count_total: got pulses=%0d sec=%0d min=%0d, expected pulses=3 sec=3 min=0",
                     pulses, o[9:4], o[15:10]);
        end
    endtask

    task automatic test_rollover;
        int cyc = 0;
        int days = 0;
        load(1'b0, 5'd0, 6'd59, 6'd59);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        load(1'b0, 5'd23, 6'd59, 6'd59);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o[1]) days++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL rollover cycle %0d: got %h, expected %h", cyc, o, e);
            end
            cyc++;
        end
        tests_run++;
        if (days !== 1 || o[15:4] !== 12'd0 || o[20:16] !== model_hour(0)) begin
            tests_failed++;
            $display("FAIL day_wrap: got days=%0d time=%h, expected days=1 time 00:00:00", days, o[20:4]);
        end
    endtask

    task automatic test_bad_load;
        int cyc = 0;
        int errs = 0;
        load(1'b0, 5'd7, 6'd8, 6'd9);
        load(1'b0, 5'd24, 6'd0, 6'd0);
        idle(1'b0, 1'b1);
        load(1'b0, 5'd0, 6'd60, 6'd0);
        load(1'b0, 5'd0, 6'd0, 6'd63);
        idle(1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o[0]) errs++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL bad_load cycle %0d: got %h, expected %h", cyc, o, e);
            end
            cyc++;
        end
        tests_run++;
        if (errs !== 3 || o[15:10] !== 6'd8 || o[9:4] !== 6'd9) begin
            tests_failed++;
            $display("FAIL bad_load_total: got errs=%0d min=%0d sec=%0d, expected errs=3 min=8 sec=9",
                     errs, o[15:10], o[9:4]);
        end
    endtask

    task automatic test_load_priority;
        int cyc = 0;
        int pulses = 0;
        idle(1'b0, 1'b1);
        load(1'b1, 5'd10, 6'd20, 6'd30);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o[2]) pulses++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL load_priority cycle %0d: got %h, expected %h", cyc, o, e);
            end
            cyc++;
        end
        tests_run++;
        if (pulses !== 0 || o[15:4] !== {6'd20, 6'd30}) begin
            tests_failed++;
            $display("FAIL load_priority_total: got pulses=%0d mm:ss=%0d:%0d, expected 0 and 20:30",
                     pulses, o[15:10], o[9:4]);
        end
    endtask

    task automatic test_run_gate;
        int cyc = 0;
        int pulses = 0;
        load(1'b0, 5'd1, 6'd2, 6'd3);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o[2]) pulses++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL run_gate cycle %0d: got %h, expected %h", cyc, o, e);
            end
            cyc++;
        end
        tests_run++;
        if (pulses !== 1 || o[9:4] !== 6'd4) begin
            tests_failed++;
            $display("FAIL run_gate_total: got pulses=%0d sec=%0d, expected pulses=1 sec=4", pulses, o[9:4]);
        end
    endtask

    task automatic test_reset_mid_rollover;
        int cyc = 0;
        load(1'b0, 5'd23, 6'd59, 6'd59);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0);
        idle(1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_mid_rollover cycle %0d: got %h, expected %h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_hour_display;
        logic [4:0] want_h0, want_h13;
        logic       want_pm0, want_pm13;
`ifdef RTC_TWELVE_HOUR_EN
        want_h0 = 5'd12; want_pm0 = 1'b0; want_h13 = 5'd1; want_pm13 = 1'b1;
`else
        want_h0 = 5'd0;  want_pm0 = 1'b0; want_h13 = 5'd13; want_pm13 = 1'b0;
`endif
        load(1'b0, 5'd0, 6'd0, 6'd0);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        tests_run++;
        if (o[20:16] !== want_h0 || o[3] !== want_pm0) begin
            tests_failed++;
            $display("FAIL hour_disp_0: got hour=%0d pm=%0b, expected hour=%0d pm=%0b", o[20:16], o[3], want_h0, want_pm0);
        end
        load(1'b0, 5'd13, 6'd5, 6'd0);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        tests_run++;
        if (o[20:16] !== want_h13 || o[3] !== want_pm13 || o[15:10] !== 6'd5) begin
            tests_failed++;
            $display("FAIL hour_disp_13: got hour=%0d pm=%0b min=%0d, expected hour=%0d pm=%0b min=5",
                     o[20:16], o[3], o[15:10], want_h13, want_pm13);
        end
    endtask

    task automatic test_random;
        int   cyc = 0;
        logic tick = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) tick = ~tick;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    drive(1'b1, tick, 1'b1, 1'b1, 5'd23, 6'd59, 6'($urandom_range(56, 59)));
                else
                    drive(1'b1, tick, 1'b1, 1'b1, 5'($urandom_range(0, 31)),
                          6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            end else if ($urandom_range(0, 99) == 0) begin
                drive(1'b0, tick, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0);
            end else begin
                idle(tick, ($urandom_range(0, 4) != 0));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL random cycle %0d: got %h, expected %h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b0; i_tick = 1'b0; i_run = 1'b0; i_set_valid = 1'b0;
        i_set_hh = 5'd0; i_set_mm = 6'd0; i_set_ss = 6'd0;
        m_h = INIT_H; m_m = 0; m_s = 0; m_prev = 1'b0;
        test_reset;
        test_count;
        test_rollover;
        test_bad_load;
        test_load_priority;
        test_run_gate;
        test_reset_mid_rollover;
        test_hour_display;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
